cpu_run_control: RTL and testbench
==================================

Name: cpu_run_control

Overview:
Downstream consumer of the prescaled CPU tick. Gates the one-cycle tick strobe into the CPU's clock-enable according to run/halt/single-step mode. Mode is selected by two raw board pushbuttons (synchronised and debounced here) and by a halt request from the CPU core. Also keeps a 16-bit count of executed CPU steps for the display logic.

Parameters:
DEBOUNCE_CYCLES, 500000, number of consecutive clk cycles a synchronised button level must differ from the debounced state before the debounced state changes. Must be >= 1. Benches override it to 4.

Ports:
clk         input   1   system clock
reset       input   1   asynchronous, active-low reset
tick        input   1   one-cycle strobe from the clock prescaler
btn_run     input   1   raw pushbuttons, active-high, asynchronous
btn_step    input   1   raw pushbuttons, active-high, asynchronous
halt_req    input   1   one-cycle pulse from the CPU core (HALT executed), synchronous to clk
cpu_en      output  1   one-cycle clock-enable to the CPU core
running     output  1   high while in RUN state
step_count  output  16  number of cpu_en pulses since reset, wrapping

Behaviour:
- Reset (reset=0, async):
  - FSM goes to HALT.
  - Synchronisers, debounced states and debounce counters go to 0.
  - step_count=0, running=0, cpu_en=0.
  - All state holds while reset is low, regardless of tick or the buttons.
- Button input path, per button, identical:
  - 2-flop synchroniser, then debounce counter (32-bit).
  - Counter clears whenever the synchronised level equals the debounced state.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1 while the level still differs, the debounced state takes the new level and the counter clears.
  - A 0->1 transition of the debounced state gives a one-cycle press pulse (run_press / step_press), registered.
  - Release produces no pulse.
  - A glitch shorter than DEBOUNCE_CYCLES synchronised cycles produces no pulse.
- FSM states: HALT, RUN, STEP.
  - HALT:
    - run_press -> RUN.
    - Otherwise step_press -> STEP.
    - If both arrive in the same cycle, run_press wins.
    - halt_req is ignored.
  - RUN:
    - halt_req -> HALT. This has priority over run_press; both together -> HALT.
    - run_press alone -> HALT.
    - step_press is ignored.
  - STEP:
    - On tick -> HALT.
    - run_press, step_press and halt_req are ignored.
    - Waits indefinitely for tick.
- cpu_en is combinational: tick AND (state==RUN OR state==STEP), using the current registered state.
  - Zero latency from tick.
  - A tick in the same cycle as a RUN->HALT transition still produces cpu_en (the state is still RUN that cycle).
  - A tick in the cycle the FSM enters RUN or STEP does not produce cpu_en (the state is not yet updated).
  - cpu_en is never high outside a tick cycle.
- running = (state==RUN), registered via the state.
- step_count:
  - Increments by 1 on every clk edge where cpu_en=1.
  - Unsigned 16-bit, wraps 0xFFFF -> 0x0000.
  - Never changes otherwise.
- Reset mid-step (reset low while in STEP): returns to HALT. No cpu_en is generated for the pending tick.
- Latency from a clean button press to the press pulse: 2 (sync) + DEBOUNCE_CYCLES + 1 cycles. The FSM changes state one cycle after the pulse.

Test Plan:
1. Reset: hold reset=0 for 20 cycles with tick pulsing every 4 cycles and both buttons high -> cpu_en=0, running=0, step_count=0 throughout. Release reset with buttons low -> still HALT.
2. Debounce (DEBOUNCE_CYCLES=4): btn_run high for 3 cycles then low -> running stays 0. btn_run high for 10 cycles -> running=1 exactly 2+4+1+1=8 cycles after the first high sample. Release -> no further state change.
3. Run: enter RUN, tick every 4 cycles for 10 ticks -> exactly 10 cpu_en pulses, each coincident with tick, step_count=10. Press run again -> HALT, subsequent ticks give no cpu_en.
4. Single step: in HALT, press btn_step, then apply 3 ticks -> exactly one cpu_en (first tick after entering STEP), step_count+1, FSM back in HALT, running=0 throughout.
5. Simultaneous events: in RUN, assert halt_req, a synthetic run_press (via button) and tick in the same cycle -> cpu_en=1 that cycle, next cycle HALT, running=0. In HALT, run and step presses in the same cycle -> RUN.
6. Wrap and reset: run 65536 ticks -> step_count returns to 0x0000. Then enter STEP, assert reset=0 before a tick arrives -> HALT, no cpu_en, step_count=0.

Source files
------------

// File: rtl/cpu_run_control.sv
// cpu_run_control: gates the prescaler tick into the CPU clock-enable
// according to HALT / RUN / STEP mode. Two raw pushbuttons are synchronised
// and debounced locally; the CPU core can request HALT. A 16-bit wrapping
// counter records every CPU step issued.
//
// Handshakes: tick, halt_req and the internal press pulses are single-cycle
// strobes, sampled on the rising clk edge; cpu_en is a same-cycle strobe
// qualified by the registered state, so it has no valid/ready back-pressure.
module cpu_run_control #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic        btn_run,
  input  logic        btn_step,
  input  logic        halt_req,
  output logic        cpu_en,
  output logic        running,
  output logic [15:0] step_count,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_HALT = 2'd0,
    S_RUN  = 2'd1,
    S_STEP = 2'd2
  } state_t;

  localparam logic [31:0] LP_LAST = 32'(DEBOUNCE_CYCLES - 1);

  // Button lanes: bit 0 = run, bit 1 = step.
  logic [1:0]  w_btn_raw;
  logic [1:0]  r_sync0;
  logic [1:0]  r_sync1;
  logic [1:0]  r_deb;
  logic [1:0]  r_deb_d;
  logic [1:0]  r_press;
  logic [31:0] r_cnt [2];

  state_t      r_state;
  state_t      w_next;
  logic        w_cpu_en;
  logic        w_run_press;
  logic        w_step_press;
  logic [15:0] r_step_count;

  assign w_btn_raw    = {btn_step, btn_run};
  assign w_run_press  = r_press[0];
  assign w_step_press = r_press[1];

  // Synchronise, debounce and edge-detect both buttons; release gives no pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync0 <= '0;
      r_sync1 <= '0;
      r_deb   <= '0;
      r_deb_d <= '0;
      r_press <= '0;
      for (int i = 0; i < 2; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_sync0 <= w_btn_raw;
      r_sync1 <= r_sync0;
      r_deb_d <= r_deb;
      r_press <= r_deb & ~r_deb_d;
      for (int i = 0; i < 2; i++) begin
        if (r_sync1[i] == r_deb[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == LP_LAST) begin
          r_deb[i] <= r_sync1[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 32'd1;
        end
      end
    end
  end

  // Mode state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_HALT;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state: run press beats step press in HALT; halt request beats run press in RUN.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_HALT: begin
        if (w_run_press) begin
          w_next = S_RUN;
        end else if (w_step_press) begin
          w_next = S_STEP;
        end
      end
      S_RUN: begin
        if (halt_req || w_run_press) begin
          w_next = S_HALT;
        end
      end
      S_STEP: begin
        if (tick) begin
          w_next = S_HALT;
        end
      end
      default: w_next = S_HALT;
    endcase
  end

  // cpu_en follows tick with zero latency, qualified by the current state only.
  assign w_cpu_en = tick && ((r_state == S_RUN) || (r_state == S_STEP));

  // Count every issued CPU step; 16-bit wrap is intentional.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_step_count <= '0;
    end else if (w_cpu_en) begin
      r_step_count <= r_step_count + 16'd1;
    end
  end

  assign cpu_en     = w_cpu_en;
  assign running    = (r_state == S_RUN);
  assign step_count = r_step_count;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_cpu_run_control.sv
// Bench for cpu_run_control with DEBOUNCE_CYCLES = 4.
module tb_cpu_run_control;

  localparam int DEB = 4;
  localparam logic [1:0] ST_HALT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_STEP = 2'd2;

  // Clock / reset
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic tick = 1'b0;
  logic btn_run = 1'b0;
  logic btn_step = 1'b0;
  logic halt_req = 1'b0;
  logic        cpu_en;
  logic        running;
  logic [15:0] step_count;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_count = 16'd0;
  logic [15:0] exp_v;

  cpu_run_control #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clk(clk),
    .reset(reset),
    .tick(tick),
    .btn_run(btn_run),
    .btn_step(btn_step),
    .halt_req(halt_req),
    .cpu_en(cpu_en),
    .running(running),
    .step_count(step_count),
    .dbg_state(dbg_state)
  );

  // Scoreboard: every expected cpu_en pulse carries the step_count it must see.
  always @(negedge clk) begin
    if (cpu_en) begin
      checks++;
      if (!tick) begin
        errors++;
        $display("FAIL cpu_en_no_tick got cpu_en=1 with tick=0, expected cpu_en=0");
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_cpu_en got cpu_en=1 (step_count=%h) expected cpu_en=0", step_count);
      end else begin
        exp_v = exp_q.pop_front();
        if (step_count !== exp_v) begin
          errors++;
          $display("FAIL pulse_count got step_count=%h expected %h", step_count, exp_v);
        end
      end
    end else if (tick && exp_q.size() != 0) begin
      checks++;
      errors++;
      exp_v = exp_q.pop_front();
      $display("FAIL missing_cpu_en got cpu_en=0 expected 1 (count %h)", exp_v);
    end
  end

  // Driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_tick(input bit expect_en);
    tick = 1'b1;
    if (expect_en) begin
      exp_q.push_back(exp_count);
      exp_count = exp_count + 16'd1;
    end
    cyc();
    tick = 1'b0;
  endtask

  task automatic press(input bit r, input bit s);
    btn_run  = r;
    btn_step = s;
    repeat (10) cyc();
    btn_run  = 1'b0;
    btn_step = 1'b0;
    repeat (12) cyc();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    btn_run = 1'b1;
    btn_step = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick = ((i % 4) == 0);
      #1;
      checks++;
      if ({cpu_en, running, step_count, dbg_state} !== 20'h0) begin
        errors++;
        $display("FAIL reset_hold cyc %0d got en=%b run=%b cnt=%h st=%0d expected all 0",
                 i, cpu_en, running, step_count, dbg_state);
      end
      cyc();
    end
    tick = 1'b0;
    btn_run = 1'b0;
    btn_step = 1'b0;
    cyc();
    reset = 1'b1;
    repeat (12) cyc();
    checks++;
    if (dbg_state !== ST_HALT || running !== 1'b0 || step_count !== 16'h0) begin
      errors++;
      $display("FAIL reset_release got st=%0d run=%b cnt=%h expected HALT 0 0", dbg_state, running, step_count);
    end
  endtask

  task automatic test_debounce();
    btn_run = 1'b1;
    repeat (3) cyc();
    btn_run = 1'b0;
    repeat (12) cyc();
    checks++;
    if (running !== 1'b0 || dbg_state !== ST_HALT) begin
      errors++;
      $display("FAIL glitch got run=%b st=%0d expected 0 HALT", running, dbg_state);
    end
    btn_run = 1'b1;
    repeat (7) cyc();
    // Press pulse is live now; a tick here must not enable the CPU yet.
    tick = 1'b1;
    checks++;
    if (running !== 1'b0) begin
      errors++;
      $display("FAIL press_early got running=%b expected 0 after 7 edges", running);
    end
    cyc();
    tick = 1'b0;
    checks++;
    if (running !== 1'b1 || dbg_state !== ST_RUN) begin
      errors++;
      $display("FAIL press_latency got run=%b st=%0d expected 1 RUN after 8 edges", running, dbg_state);
    end
    repeat (2) cyc();
    btn_run = 1'b0;
    repeat (12) cyc();
    checks++;
    if (dbg_state !== ST_RUN) begin
      errors++;
      $display("FAIL release got st=%0d expected RUN", dbg_state);
    end
  endtask

  task automatic test_run();
    for (int i = 0; i < 10; i++) begin
      pulse_tick(1'b1);
      repeat (3) cyc();
    end
    checks++;
    if (step_count !== 16'd10) begin
      errors++;
      $display("FAIL run_count got %0d expected 10", step_count);
    end
    press(1'b1, 1'b0);
    checks++;
    if (dbg_state !== ST_HALT || running !== 1'b0) begin
      errors++;
      $display("FAIL run_stop got st=%0d run=%b expected HALT 0", dbg_state, running);
    end
    for (int i = 0; i < 3; i++) begin
      pulse_tick(1'b0);
      repeat (3) cyc();
    end
    checks++;
    if (step_count !== 16'd10) begin
      errors++;
      $display("FAIL halt_count got %0d expected 10", step_count);
    end
  endtask

  task automatic test_single_step();
    press(1'b0, 1'b1);
    checks++;
    if (dbg_state !== ST_STEP || running !== 1'b0) begin
      errors++;
      $display("FAIL step_enter got st=%0d run=%b expected STEP 0", dbg_state, running);
    end
    pulse_tick(1'b1);
    checks++;
    if (dbg_state !== ST_HALT || running !== 1'b0) begin
      errors++;
      $display("FAIL step_exit got st=%0d run=%b expected HALT 0", dbg_state, running);
    end
    for (int i = 0; i < 2; i++) begin
      repeat (3) cyc();
      pulse_tick(1'b0);
    end
    checks++;
    if (step_count !== 16'd11 || running !== 1'b0) begin
      errors++;
      $display("FAIL step_count got %0d run=%b expected 11 0", step_count, running);
    end
  endtask

  task automatic test_simultaneous();
    press(1'b1, 1'b0);
    checks++;
    if (dbg_state !== ST_RUN) begin
      errors++;
      $display("FAIL sim_enter got st=%0d expected RUN", dbg_state);
    end
    btn_run = 1'b1;
    repeat (7) cyc();
    halt_req = 1'b1;
    pulse_tick(1'b1);
    halt_req = 1'b0;
    checks++;
    if (dbg_state !== ST_HALT || running !== 1'b0) begin
      errors++;
      $display("FAIL sim_halt got st=%0d run=%b expected HALT 0", dbg_state, running);
    end
    btn_run = 1'b0;
    repeat (12) cyc();
    checks++;
    if (dbg_state !== ST_HALT) begin
      errors++;
      $display("FAIL sim_settle got st=%0d expected HALT", dbg_state);
    end
    press(1'b1, 1'b1);
    checks++;
    if (dbg_state !== ST_RUN || running !== 1'b1) begin
      errors++;
      $display("FAIL both_press got st=%0d run=%b expected RUN 1", dbg_state, running);
    end
    halt_req = 1'b1;
    cyc();
    halt_req = 1'b0;
    checks++;
    if (dbg_state !== ST_HALT) begin
      errors++;
      $display("FAIL halt_req got st=%0d expected HALT", dbg_state);
    end
  endtask

  task automatic test_wrap_and_reset();
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    exp_count = 16'd0;
    cyc();
    checks++;
    if (step_count !== 16'd0) begin
      errors++;
      $display("FAIL wrap_start got %h expected 0000", step_count);
    end
    press(1'b1, 1'b0);
    for (int i = 0; i < 65536; i++) begin
      if (i == 65535) begin
        checks++;
        if (step_count !== 16'hFFFF) begin
          errors++;
          $display("FAIL pre_wrap got %h expected FFFF", step_count);
        end
      end
      pulse_tick(1'b1);
    end
    checks++;
    if (step_count !== 16'h0000) begin
      errors++;
      $display("FAIL wrap got %h expected 0000", step_count);
    end
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    checks++;
    if (dbg_state !== ST_STEP) begin
      errors++;
      $display("FAIL wrap_step got st=%0d expected STEP", dbg_state);
    end
    reset = 1'b0;
    #1;
    tick = 1'b1;
    #1;
    checks++;
    if (dbg_state !== ST_HALT || cpu_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_step got st=%0d en=%b expected HALT 0", dbg_state, cpu_en);
    end
    cyc();
    tick = 1'b0;
    reset = 1'b1;
    repeat (3) cyc();
    checks++;
    if (dbg_state !== ST_HALT || step_count !== 16'h0) begin
      errors++;
      $display("FAIL after_reset got st=%0d cnt=%h expected HALT 0000", dbg_state, step_count);
    end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_run();
    test_single_step();
    test_simultaneous();
    test_wrap_and_reset();
    repeat (4) cyc();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_pulses got %0d left expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
